// File: rtl/logic_unit_scheduler_if.sv
// rtl/logic_unit_scheduler_if.sv - request/result handshake bundle for the shared logic unit
interface logic_unit_scheduler_if #(
    parameter int K = 16
);
    logic         req0_valid;
    logic         req0_ready;
    logic [2:0]   req0_op;
    logic [K-1:0] req0_a;
    logic [K-1:0] req0_b;

    logic         req1_valid;
    logic         req1_ready;
    logic [2:0]   req1_op;
    logic [K-1:0] req1_a;
    logic [K-1:0] req1_b;

    logic         res_valid;
    logic         res_ready;
    logic [K-1:0] res_data;
    logic         res_id;
    logic         res_err;

    // Requesters and result consumer side
    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  res_valid, res_data, res_id, res_err,
        output res_ready
    );

    // Scheduler side
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output res_valid, res_data, res_id, res_err,
        input  res_ready
    );
endinterface

// File: rtl/logic_unit_scheduler.sv
// rtl/logic_unit_scheduler.sv - round-robin sharing of one bitwise logic unit between two requesters
module logic_unit_scheduler #(
    parameter int K  = 16,
    parameter int CW = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    logic_unit_scheduler_if.slave  bus,
    output logic                   busy,
    output logic [CW-1:0]          op_count
);

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t       state;
    state_t       state_nxt;

    logic         last_grant;
    logic         grant;
    logic         can_accept;
    logic         accept0;
    logic         accept1;
    logic         accept;

    logic [2:0]   sel_op;
    logic [K-1:0] sel_a;
    logic [K-1:0] sel_b;
    logic [K-1:0] alu_result;
    logic         alu_err;

    logic [K-1:0] res_data_q;
    logic         res_id_q;
    logic         res_err_q;

    // Pick the requester: a lone valid wins, contention goes to whoever did not win last
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
    end

    // Handshake qualification; reset blocks all accepts so nothing is lost mid-reset
    always_comb begin
        can_accept = (state == IDLE) || bus.res_ready;
        accept0    = !rst && can_accept && bus.req0_valid && (grant == 1'b0);
        accept1    = !rst && can_accept && bus.req1_valid && (grant == 1'b1);
        accept     = accept0 || accept1;
    end

    // Operand mux feeding the single shared logic unit
    always_comb begin
        sel_op = grant ? bus.req1_op : bus.req0_op;
        sel_a  = grant ? bus.req1_a  : bus.req0_a;
        sel_b  = grant ? bus.req1_b  : bus.req0_b;
    end

    // The shared bitwise unit; opcode 7 yields zero and flags an error
    always_comb begin
        alu_err = 1'b0;
        case (sel_op)
            3'd0:    alu_result = sel_a & sel_b;
            3'd1:    alu_result = sel_a | sel_b;
            3'd2:    alu_result = sel_a ^ sel_b;
            3'd3:    alu_result = ~sel_a;
            3'd4:    alu_result = ~(sel_a | sel_b);
            3'd5:    alu_result = ~(sel_a ^ sel_b);
            3'd6:    alu_result = ~(sel_a & sel_b);
            default: begin
                alu_result = '0;
                alu_err    = 1'b1;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: any accept fills the slot, a drain without refill empties it
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (accept) begin
                    state_nxt = FULL;
                end else if (bus.res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: slot occupancy and per-requester ready
    always_comb begin
        bus.res_valid  = (state == FULL);
        busy           = (state == FULL);
        bus.req0_ready = accept0;
        bus.req1_ready = accept1;
    end

    // Result slot loads only on accept, so it holds steady under back-pressure
    always_ff @(posedge clk) begin
        if (rst) begin
            res_data_q <= '0;
            res_id_q   <= 1'b0;
            res_err_q  <= 1'b0;
        end else if (accept) begin
            res_data_q <= alu_result;
            res_id_q   <= grant;
            res_err_q  <= alu_err;
        end
    end

    // Round-robin history and accepted-operation counter
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            op_count   <= '0;
        end else if (accept) begin
            last_grant <= grant;
            op_count   <= op_count + CW'(1);
        end
    end

    // Drive result payload onto the bundle
    always_comb begin
        bus.res_data = res_data_q;
        bus.res_id   = res_id_q;
        bus.res_err  = res_err_q;
    end

endmodule

// File: tb/tb_logic_unit_scheduler.sv
// tb/tb_logic_unit_scheduler.sv - directed self-checking bench for logic_unit_scheduler
module tb_logic_unit_scheduler;

    localparam int K  = 16;
    localparam int CW = 8;

    logic          clk;
    logic          rst;
    logic          busy;
    logic [CW-1:0] op_count;

    int checks;
    int errors;

    logic_unit_scheduler_if #(.K(K)) bus ();

    logic_unit_scheduler #(.K(K), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] sweep_exp [1:7];

    initial begin
        checks = 0;
        errors = 0;
        sweep_exp[1] = 16'hFFFF;
        sweep_exp[2] = 16'hFCFC;
        sweep_exp[3] = 16'h5454;
        sweep_exp[4] = 16'h0000;
        sweep_exp[5] = 16'h0303;
        sweep_exp[6] = 16'hFCFC;
        sweep_exp[7] = 16'h0000;

        rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_op = 3'd0; bus.req0_a = 16'hABAB; bus.req0_b = 16'h5757;
        bus.req1_valid = 1'b1; bus.req1_op = 3'd0; bus.req1_a = '0;       bus.req1_b = '0;
        bus.res_ready  = 1'b1;

        // Reset state, readies held low while reset is asserted
        tick();
        tick();
        check("rst_ready0", 32'(bus.req0_ready), 32'd0);
        check("rst_ready1", 32'(bus.req1_ready), 32'd0);
        check("rst_valid", 32'(bus.res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(op_count), 32'd0);
        check("rst_data", 32'(bus.res_data), 32'd0);

        // Test 1: single AND from requester 0
        rst = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        check("t1_ready0", 32'(bus.req0_ready), 32'd1);
        tick();
        check("t1_valid", 32'(bus.res_valid), 32'd1);
        check("t1_data", 32'(bus.res_data), 32'h0303);
        check("t1_id", 32'(bus.res_id), 32'd0);
        check("t1_err", 32'(bus.res_err), 32'd0);
        check("t1_count", 32'(op_count), 32'd1);

        // Test 2: opcode sweep back-to-back on the same operands
        for (int op = 1; op <= 7; op++) begin
            bus.req0_op = 3'(op);
            #1;
            check($sformatf("t2_ready_op%0d", op), 32'(bus.req0_ready), 32'd1);
            tick();
            check($sformatf("t2_data_op%0d", op), 32'(bus.res_data), 32'(sweep_exp[op]));
            check($sformatf("t2_err_op%0d", op), 32'(bus.res_err), (op == 7) ? 32'd1 : 32'd0);
        end
        check("t2_count", 32'(op_count), 32'd8);
        bus.req0_valid = 1'b0;
        tick();
        check("t2_drain_valid", 32'(bus.res_valid), 32'd0);

        // Test 3: continuous contention; requester 0 won last, so requester 1 goes first
        bus.req0_op = 3'd0; bus.req0_a = 16'h00FF; bus.req0_b = 16'h0F0F;
        bus.req1_op = 3'd1; bus.req1_a = 16'hF000; bus.req1_b = 16'h000F;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("t3_r0_%0d", i), 32'(bus.req0_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
            check($sformatf("t3_r1_%0d", i), 32'(bus.req1_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            tick();
            check($sformatf("t3_id_%0d", i), 32'(bus.res_id), (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("t3_data_%0d", i), 32'(bus.res_data), (i % 2 == 0) ? 32'hF00F : 32'h000F);
        end
        check("t3_count", 32'(op_count), 32'd12);

        // Test 4: back-pressure while full with both requesters waiting
        bus.res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("t4_r0_%0d", i), 32'(bus.req0_ready), 32'd0);
            check($sformatf("t4_r1_%0d", i), 32'(bus.req1_ready), 32'd0);
            tick();
            check($sformatf("t4_valid_%0d", i), 32'(bus.res_valid), 32'd1);
            check($sformatf("t4_data_%0d", i), 32'(bus.res_data), 32'h000F);
            check($sformatf("t4_id_%0d", i), 32'(bus.res_id), 32'd0);
        end
        check("t4_count_held", 32'(op_count), 32'd12);
        bus.res_ready = 1'b1;
        #1;
        check("t4_release_r1", 32'(bus.req1_ready), 32'd1);
        check("t4_release_r0", 32'(bus.req0_ready), 32'd0);
        tick();
        check("t4_release_id", 32'(bus.res_id), 32'd1);
        check("t4_release_data", 32'(bus.res_data), 32'hF00F);
        check("t4_release_count", 32'(op_count), 32'd13);

        // Test 5: reset while full, then contention resolves to requester 0
        bus.res_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("t5_rst_r0", 32'(bus.req0_ready), 32'd0);
        check("t5_rst_r1", 32'(bus.req1_ready), 32'd0);
        tick();
        check("t5_valid", 32'(bus.res_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_count", 32'(op_count), 32'd0);
        check("t5_data", 32'(bus.res_data), 32'd0);
        rst = 1'b0;
        bus.res_ready = 1'b1;
        #1;
        check("t5_first_r0", 32'(bus.req0_ready), 32'd1);
        check("t5_first_r1", 32'(bus.req1_ready), 32'd0);
        tick();
        check("t5_first_id", 32'(bus.res_id), 32'd0);
        check("t5_first_count", 32'(op_count), 32'd1);

        // Test 6: counter wraps after 2^CW accepts from reset
        rst = 1'b1;
        bus.req1_valid = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= (1 << CW); i++) begin
            tick();
            if (i == (1 << CW) - 1) begin
                check("t6_count_max", 32'(op_count), 32'd255);
            end
        end
        check("t6_count_wrap", 32'(op_count), 32'd0);
        check("t6_valid", 32'(bus.res_valid), 32'd1);
        check("t6_data", 32'(bus.res_data), 32'h000F);
        check("t6_id", 32'(bus.res_id), 32'd0);
        check("t6_err", 32'(bus.res_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
